page_stream_scatter: RTL and testbench

PAGE_STREAM_SCATTER -- requirements
Module: page_stream_scatter

---
 rtl/page_stream_scatter.sv | 154 +++++++++++++++
 tb/tb_page_stream_scatter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_stream_scatter.sv
// Scatters an input token stream across NCH output channels. Tokens pass
// through a small FIFO; end-of-stream tokens are broadcast to every channel.
module page_stream_scatter #(
  parameter int WIDTH  = 16,
  parameter int NCH    = 8,
  parameter int QDEPTH = 4,
  parameter int MODE   = 0,
  parameter int RUN    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_d,
  input  logic                 in_e,
  input  logic                 in_v,
  output logic                 in_b,
  output logic [NCH*WIDTH-1:0] ch_d,
  output logic [NCH-1:0]       ch_e,
  output logic [NCH-1:0]       ch_v,
  input  logic [NCH-1:0]       ch_b
);

  localparam int AW = $clog2(QDEPTH);
  localparam int IW = $clog2(NCH);
  localparam int RW = 8;

  // FIFO storage: each entry is {eos, data}
  logic [WIDTH:0]   r_mem [QDEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_in_b;

  logic [IW-1:0]    r_idx;
  logic [RW-1:0]    r_run;

  logic [WIDTH-1:0] r_ch_d [NCH];
  logic [NCH-1:0]   r_ch_e;
  logic [NCH-1:0]   r_ch_v;

  logic             w_push;
  logic             w_pop;
  logic             w_head_valid;
  logic             w_head_e;
  logic [WIDTH-1:0] w_head_d;
  logic [NCH-1:0]   w_free;
  logic [NCH-1:0]   w_load;
  logic             w_all_free;
  logic             w_target_free;
  logic [AW:0]      w_count_next;
  logic [IW-1:0]    w_idx_next;
  logic [RW-1:0]    w_run_next;
  logic [IW-1:0]    w_idx_adv;

  assign w_push       = in_v & ~r_in_b;
  assign w_head_valid = (r_count != '0);
  assign {w_head_e, w_head_d} = r_mem[r_rd_ptr];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign w_free[gi] = ~r_ch_v[gi] | ~ch_b[gi];
      assign w_load[gi] = w_pop & (w_head_e | (r_idx == IW'(gi)));
      assign ch_d[gi*WIDTH +: WIDTH] = r_ch_d[gi];
    end
  endgenerate

  assign w_all_free    = &w_free;
  assign w_target_free = w_free[r_idx];
  // EOS must wait for every channel so the broadcast lands in one edge
  assign w_pop = w_head_valid & (w_head_e ? w_all_free : w_target_free);

  assign w_idx_adv = (r_idx == IW'(NCH-1)) ? '0 : r_idx + IW'(1);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (AW+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - (AW+1)'(1);
    end
  end

  always_comb begin
    w_idx_next = r_idx;
    w_run_next = r_run;
    if (w_pop) begin
      if (w_head_e) begin
        w_idx_next = '0;
        w_run_next = '0;
      end else if (MODE == 0) begin
        w_idx_next = w_idx_adv;
      end else if (r_run == RW'(RUN-1)) begin
        w_run_next = '0;
        w_idx_next = w_idx_adv;
      end else begin
        w_run_next = r_run + RW'(1);
      end
    end
  end

  // Storage is not reset; emptiness is tracked solely by the pointers/count
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_e, in_d};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_in_b   <= 1'b0;
      r_idx    <= '0;
      r_run    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_in_b  <= (w_count_next == (AW+1)'(QDEPTH));
      r_idx   <= w_idx_next;
      r_run   <= w_run_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ch_e <= '0;
      r_ch_v <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_ch_d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_load[k]) begin
          r_ch_v[k] <= 1'b1;
          r_ch_d[k] <= w_head_d;
          r_ch_e[k] <= w_head_e;
        end else if (w_free[k]) begin
          r_ch_v[k] <= 1'b0;
        end
      end
    end
  end

  assign in_b = r_in_b;
  assign ch_e = r_ch_e;
  assign ch_v = r_ch_v;

endmodule

// File: tb/tb_page_stream_scatter.sv
// Directed bench for page_stream_scatter: per-channel expected-token queues
// filled on input acceptance and drained as channels hand tokens off.
module tb_page_stream_scatter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // instance 0: MODE 0, NCH 8, QDEPTH 4
  logic         reset;
  logic [15:0]  in_d;
  logic         in_e;
  logic         in_v;
  logic         in_b;
  logic [127:0] ch_d;
  logic [7:0]   ch_e;
  logic [7:0]   ch_v;
  logic [7:0]   ch_b;

  // instance 1: MODE 1, RUN 2, NCH 4
  logic         rst1;
  logic [15:0]  in_d1;
  logic         in_e1;
  logic         in_v1;
  logic         in_b1;
  logic [63:0]  ch_d1;
  logic [3:0]   ch_e1;
  logic [3:0]   ch_v1;
  logic [3:0]   ch_b1;

  page_stream_scatter #(.WIDTH(16), .NCH(8), .QDEPTH(4), .MODE(0), .RUN(8)) u_dut0 (
    .clock(clock), .reset(reset), .in_d(in_d), .in_e(in_e), .in_v(in_v), .in_b(in_b),
    .ch_d(ch_d), .ch_e(ch_e), .ch_v(ch_v), .ch_b(ch_b)
  );

  page_stream_scatter #(.WIDTH(16), .NCH(4), .QDEPTH(4), .MODE(1), .RUN(2)) u_dut1 (
    .clock(clock), .reset(rst1), .in_d(in_d1), .in_e(in_e1), .in_v(in_v1), .in_b(in_b1),
    .ch_d(ch_d1), .ch_e(ch_e1), .ch_v(ch_v1), .ch_b(ch_b1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic saw_inb;
  logic done1;
  int m_idx;

  logic [16:0] exp_q0 [8][$];
  logic [16:0] exp_q1 [4][$];

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (in_b) saw_inb = 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %h, required %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_accept(input logic [15:0] d, input logic e);
    if (e) begin
      for (int k = 0; k < 8; k++) exp_q0[k].push_back({1'b1, d});
      m_idx = 0;
    end else begin
      exp_q0[m_idx].push_back({1'b0, d});
      m_idx = (m_idx + 1) % 8;
    end
  endtask

  function automatic int pending0();
    int s = 0;
    for (int k = 0; k < 8; k++) s += exp_q0[k].size();
    return s;
  endfunction

  function automatic int pending1();
    int s = 0;
    for (int k = 0; k < 4; k++) s += exp_q1[k].size();
    return s;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 8; k++) exp_q0[k].delete();
    m_idx = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [15:0] d, input logic e);
    int n = 0;
    in_d = d;
    in_e = e;
    in_v = 1'b1;
    @(negedge clock);
    while (in_b && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: got in_b=1 for %0d cycles, required release", n);
    end
    model_accept(d, e);
    @(posedge clock);
    #1;
    in_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    logic [16:0] obs;
    logic [16:0] exp_v;
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        if (ch_v[k] && !ch_b[k]) begin
          obs = {ch_e[k], ch_d[k*16 +: 16]};
          checks++;
          assert (exp_q0[k].size() != 0) else begin
            errors++;
            $error("FAIL ch%0d_unexpected: got %h, required no token", k, obs);
          end
          if (exp_q0[k].size() != 0) begin
            exp_v = exp_q0[k].pop_front();
            checks++;
            assert (obs === exp_v) else begin
              errors++;
              $error("FAIL ch%0d_token: got %h, required %h", k, obs, exp_v);
            end
            $display("dut0 ch%0d out e=%0b d=%h", k, obs[16], obs[15:0]);
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [16:0] obs;
    logic [16:0] exp_v;
    if (rst1) begin
      for (int k = 0; k < 4; k++) begin
        if (ch_v1[k] && !ch_b1[k]) begin
          obs = {ch_e1[k], ch_d1[k*16 +: 16]};
          checks++;
          assert (exp_q1[k].size() != 0) else begin
            errors++;
            $error("FAIL dut1_ch%0d_unexpected: got %h, required no token", k, obs);
          end
          if (exp_q1[k].size() != 0) begin
            exp_v = exp_q1[k].pop_front();
            checks++;
            assert (obs === exp_v) else begin
              errors++;
              $error("FAIL dut1_ch%0d_token: got %h, required %h", k, obs, exp_v);
            end
            $display("dut1 ch%0d out e=%0b d=%h", k, obs[16], obs[15:0]);
          end
        end
      end
    end
  end

  // Run-blocked instance: with RUN=2 and 4 channels, token i lands on (i/2)%4
  initial begin
    int n;
    rst1 = 1'b0; in_v1 = 1'b0; in_d1 = '0; in_e1 = 1'b0; ch_b1 = '0; done1 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rst1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_d1 = 16'(i);
      in_v1 = 1'b1;
      n = 0;
      @(negedge clock);
      while (in_b1 && n < 100) begin
        @(negedge clock);
        n++;
      end
      exp_q1[(i / 2) % 4].push_back({1'b0, 16'(i)});
      @(posedge clock);
      #1;
    end
    in_v1 = 1'b0;
    repeat (6) @(posedge clock);
    done1 = 1'b1;
  end

  initial begin
    int t0;
    int n;
    logic full;
    reset = 1'b0; in_v = 1'b0; in_d = '0; in_e = 1'b0; ch_b = '0; m_idx = 0;
    #1;
    chk("rst_ch_v", 128'(ch_v), 0);
    chk("rst_ch_e", 128'(ch_e), 0);
    chk("rst_ch_d", ch_d, 0);
    chk("rst_in_b", 128'(in_b), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // Round-robin, no back-pressure, back-to-back
    saw_inb = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 16; i++) send(16'(i), 1'b0);
    chk("rr_rate_cycles", 128'(cyc - t0), 16);
    idle(6);
    chk("rr_in_b_low", 128'(saw_inb), 0);
    chk("rr_drained", 128'(pending0()), 0);

    // EOS waits behind a blocked channel, then broadcasts
    ch_b = 8'h02;
    send(16'd0, 1'b0);
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    send(16'hFFFF, 1'b1);
    idle(4);
    chk("eos_wait_ch_v", 128'(ch_v), 128'h02);
    chk("eos_wait_ch_e", 128'(ch_e), 0);
    chk("eos_wait_ch1_d", 128'(ch_d[31:16]), 128'h1);
    ch_b = 8'h00;
    @(posedge clock);
    #1;
    chk("eos_bcast_ch_v", 128'(ch_v), 128'hFF);
    chk("eos_bcast_ch_e", 128'(ch_e), 128'hFF);
    chk("eos_bcast_ch_d", ch_d, {8{16'hFFFF}});
    send(16'd5, 1'b0);
    idle(3);
    chk("eos_after_drained", 128'(pending0()), 0);
    send(16'hAAAA, 1'b1);
    idle(3);

    // Channel 0 held: stall at token 8, FIFO fills, then release
    ch_b = 8'h01;
    fork
      for (int i = 0; i < 13; i++) send(16'(i), 1'b0);
      begin
        n = 0;
        @(negedge clock);
        while (!in_b && n < 100) begin
          @(negedge clock);
          n++;
        end
        chk("hold_in_b_full", 128'(in_b), 1);
        chk("hold_ch_v", 128'(ch_v), 128'h01);
        chk("hold_ch0_d", 128'(ch_d[15:0]), 0);
        repeat (3) @(negedge clock);
        chk("hold_in_b_stays", 128'(in_b), 1);
        chk("hold_ch0_stable", 128'(ch_d[15:0]), 0);
        @(posedge clock);
        #1;
        ch_b = 8'h00;
      end
    join
    idle(8);
    chk("hold_drained", 128'(pending0()), 0);

    // Mid-stream reset with a full FIFO
    ch_b = 8'hFF;
    n = 0;
    full = 1'b0;
    while (!full && n < 40) begin
      in_d = 16'(256 + n);
      in_e = 1'b0;
      in_v = 1'b1;
      @(negedge clock);
      if (in_b) begin
        full = 1'b1;
      end else begin
        model_accept(in_d, 1'b0);
        @(posedge clock);
        #1;
      end
      n++;
    end
    @(posedge clock);
    #1;
    in_v = 1'b0;
    chk("mid_fifo_full", 128'(full), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ch_v", 128'(ch_v), 0);
    chk("mid_rst_ch_e", 128'(ch_e), 0);
    chk("mid_rst_ch_d", ch_d, 0);
    chk("mid_rst_in_b", 128'(in_b), 0);
    clear_model();
    @(posedge clock);
    #1;
    ch_b = 8'h00;
    @(posedge clock);
    #1;
    reset = 1'b1;
    send(16'h1234, 1'b0);
    chk("post_rst_not_early", 128'(ch_v), 0);
    @(posedge clock);
    #1;
    chk("post_rst_ch_v", 128'(ch_v), 128'h01);
    chk("post_rst_ch0_d", 128'(ch_d[15:0]), 128'h1234);
    idle(3);
    chk("post_rst_drained", 128'(pending0()), 0);

    n = 0;
    while (!done1 && n < 500) begin
      @(posedge clock);
      n++;
    end
    chk("run_mode_done", 128'(done1), 1);
    chk("run_mode_drained", 128'(pending1()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
